button_event_scheduler: RTL
===========================

// Module: button_event_scheduler
// PURPOSE
//  Turns N debounced button levels (one debouncer per button, upstream) into discrete
//  PRESS / RELEASE / LONG_PRESS events. Events from all buttons share one output channel
//  through a round-robin arbiter with a valid/ready handshake. Sits between the debouncer
//  bank and the sensor/UI control FSM that consumes user commands.
// PARAMETERS
//  N_BTN        4           number of buttons (2..16)
//  LONG_CYCLES  50_000_000  hold time for LONG_PRESS, in clk cycles (1 s at 50 MHz); >= 2
//  CNT_W        26          hold-timer width; must hold LONG_CYCLES-1
// PORTS
//  clk          in   1                 system clock, all logic on posedge
//  rst          in   1                 synchronous reset, active-high
//  btn_state    in   N_BTN             debounced levels, 1 = pressed
//  evt_ready    in   1                 consumer accepts event when evt_valid && evt_ready
//  evt_valid    out  1                 event present on evt_id / evt_type
//  evt_id       out  $clog2(N_BTN)     index of the source button
//  evt_type     out  2                 0 = PRESS, 1 = RELEASE, 2 = LONG_PRESS (3 unused)
//  ovf          out  1                 sticky: a pending event was overwritten
//  ovf_clr      in   1                 clears ovf (set wins if both occur in one cycle)
// BEHAVIOUR
//  - Reset: evt_valid=0, evt_id=0, evt_type=0, ovf=0; prev levels, pending flags, timers,
//    and RR pointer all 0. A button held through reset yields a PRESS after reset release.
//  - Edge detect per button vs registered previous level: 0->1 sets press_pend,
//    1->0 sets rel_pend.
//  - Hold timer per button: clears while the level is 0; counts while it is 1 and
//    long_done=0. At count == LONG_CYCLES-1, set long_pend and long_done (single fire);
//    long_done clears on release. Timer never wraps.
//  - A pending flag is set while already 1 and not granted that cycle -> ovf<=1; the
//    events merge (one delivered). Set and grant in the same cycle -> flag stays 1,
//    no ovf.
//  - Within a button, serve in order PRESS > LONG_PRESS > RELEASE (matches time order).
//  - Arbiter: a button is eligible if any of its flags is set. Grant the first eligible
//    button at or after rr_ptr (wrapping). rr_ptr <= granted+1 mod N_BTN on each grant.
//  - Output slot: single register. A grant occurs when !evt_valid || evt_ready; the granted
//    flag clears that cycle. Accept without a new grant -> evt_valid<=0.
//  - Stability: while evt_valid && !evt_ready, evt_id and evt_type are held unchanged.
//  - Latency: btn edge at clock t -> flag set at t+1 -> evt_valid at t+2 when the slot is
//    free and no other button is eligible. Throughput: 1 event/cycle with evt_ready=1.
//  - Release before LONG_CYCLES: PRESS and RELEASE only. Held past it: PRESS, LONG,
//    RELEASE.
//  - Reset mid-transfer: evt_valid drops next cycle; in-flight and pending events are lost.
// STRUCTURE
//  - Package button_evt_pkg: localparams EVT_PRESS=2'd0, EVT_RELEASE=2'd1,
//    EVT_LONG=2'd2 and the evt_type width; shared with the consumer FSM.
//  - Sub-module button_evt_tracker (one per button, generate loop): edge detect, hold timer,
//    long_done, three pending flags, per-flag ovf pulse, grant/clear input.
//  - Top: RR arbiter, output register, ovf OR-reduce and sticky register.
// TESTING (bench uses LONG_CYCLES=8, N_BTN=4)
//  1. btn[1] 0->1 for 3 cycles, then 0, ready=1 -> (1,PRESS) then (1,RELEASE); no LONG;
//     ovf=0.
//  2. btn[2] held 20 cycles -> (2,PRESS); (2,LONG) exactly once, 8 cycles after the edge;
//     (2,RELEASE) after drop.
//  3. btn[0..3] rise in the same cycle, ready=1, rr_ptr=0 -> PRESS ids 0,1,2,3 on
//     consecutive cycles.
//  4. ready=0 with event (3,PRESS) pending; btn[0] edges -> output holds (3,PRESS) until
//     ready, then (0,PRESS).
//  5. ready=0, btn[1] pulses 1-0-1 twice -> second PRESS merges, ovf=1; ovf_clr -> ovf=0.
//  6. rst asserted 1 cycle while evt_valid=1 and flags pending -> all outputs 0; button held
//     high gives a fresh PRESS.

Source files
------------

// File: rtl/button_evt_pkg.sv
// ============================================================================
// Module : button_evt_pkg
// Brief  : Event type encoding shared by the scheduler and the consumer FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package button_evt_pkg;

   localparam int EVT_TYPE_W = 2;

   typedef logic [EVT_TYPE_W-1:0] evt_type_t;

   localparam evt_type_t EVT_PRESS   = 2'd0;
   localparam evt_type_t EVT_RELEASE = 2'd1;
   localparam evt_type_t EVT_LONG    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/button_evt_tracker.sv
// ============================================================================
// Module : button_evt_tracker
// Brief  : Per-button edge detect, hold timer and PRESS/LONG/RELEASE pending flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_evt_tracker
   import button_evt_pkg::*;
#(
   parameter int LONG_CYCLES = 8,
   parameter int CNT_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_level,
   input  logic                  i_grant,
   output logic                  o_eligible,
   output logic [EVT_TYPE_W-1:0] o_type,
   output logic                  o_ovf
);

   logic             r_prev;
   logic             r_long_done;
   logic             r_press;
   logic             r_long;
   logic             r_rel;
   logic [CNT_W-1:0] r_cnt;

   logic w_rise;
   logic w_fall;
   logic w_long_hit;
   logic w_clr_press;
   logic w_clr_long;
   logic w_clr_rel;

   assign w_rise     = i_level & ~r_prev;
   assign w_fall     = ~i_level & r_prev;
   assign w_long_hit = i_level & ~r_long_done & (r_cnt == CNT_W'(LONG_CYCLES - 1));

   // A grant always serves the highest-priority pending flag, which is also the oldest.
   assign w_clr_press = i_grant & r_press;
   assign w_clr_long  = i_grant & ~r_press & r_long;
   assign w_clr_rel   = i_grant & ~r_press & ~r_long & r_rel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev      <= 1'b0;
         r_long_done <= 1'b0;
         r_cnt       <= '0;
         r_press     <= 1'b0;
         r_long      <= 1'b0;
         r_rel       <= 1'b0;
      end else begin
         r_prev <= i_level;
         if (!i_level) begin
            r_cnt       <= '0;
            r_long_done <= 1'b0;
         end else if (!r_long_done) begin
            if (w_long_hit) begin
               r_long_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         r_press <= w_rise     | (r_press & ~w_clr_press);
         r_long  <= w_long_hit | (r_long  & ~w_clr_long);
         r_rel   <= w_fall     | (r_rel   & ~w_clr_rel);
      end
   end

   always_comb begin
      o_eligible = r_press | r_long | r_rel;
      o_type     = EVT_RELEASE;
      if (r_press) begin
         o_type = EVT_PRESS;
      end else if (r_long) begin
         o_type = EVT_LONG;
      end
   end

   assign o_ovf = (w_rise     & r_press & ~w_clr_press)
                | (w_long_hit & r_long  & ~w_clr_long)
                | (w_fall     & r_rel   & ~w_clr_rel);

endmodule

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// ============================================================================
// Module : button_event_scheduler
// Brief  : Per-button event trackers merged onto one valid/ready channel by RR arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_event_scheduler
   import button_evt_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int LONG_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_BTN-1:0]         i_btn_state,
   input  logic                     i_evt_ready,
   output logic                     o_evt_valid,
   output logic [$clog2(N_BTN)-1:0] o_evt_id,
   output logic [EVT_TYPE_W-1:0]    o_evt_type,
   output logic                     o_ovf,
   input  logic                     i_ovf_clr
);

   localparam int ID_W  = $clog2(N_BTN);
   localparam int SUM_W = ID_W + 1;

   logic [N_BTN-1:0]      w_elig;
   logic [N_BTN-1:0]      w_grant_vec;
   logic [N_BTN-1:0]      w_ovf_vec;
   logic [EVT_TYPE_W-1:0] w_type [N_BTN];

   logic [ID_W-1:0]       w_gnt_id;
   logic [ID_W-1:0]       w_idx;
   logic [SUM_W-1:0]      w_sum;
   logic                  w_found;
   logic                  w_grant;

   logic                  r_valid;
   logic [ID_W-1:0]       r_id;
   logic [EVT_TYPE_W-1:0] r_type;
   logic [ID_W-1:0]       r_rr_ptr;
   logic                  r_ovf;

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_tracker
         button_evt_tracker #(
            .LONG_CYCLES (LONG_CYCLES),
            .CNT_W       (CNT_W)
         ) u_tracker (
            .clk        (clk),
            .rst        (rst),
            .i_level    (i_btn_state[gi]),
            .i_grant    (w_grant_vec[gi]),
            .o_eligible (w_elig[gi]),
            .o_type     (w_type[gi]),
            .o_ovf      (w_ovf_vec[gi])
         );
         assign w_grant_vec[gi] = w_grant & (w_gnt_id == ID_W'(gi));
      end
   endgenerate

   // Scan from the RR pointer with wrap-around; the first eligible button wins.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = 0; k < N_BTN; k++) begin
         w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
         if (w_sum >= SUM_W'(N_BTN)) begin
            w_sum = w_sum - SUM_W'(N_BTN);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!w_found && w_elig[w_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx;
         end
      end
   end

   assign w_grant = w_found & (~r_valid | i_evt_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_id     <= '0;
         r_type   <= EVT_PRESS;
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         r_valid  <= 1'b1;
         r_id     <= w_gnt_id;
         r_type   <= w_type[w_gnt_id];
         r_rr_ptr <= (w_gnt_id == ID_W'(N_BTN - 1)) ? '0 : w_gnt_id + ID_W'(1);
      end else if (i_evt_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Overwrite indication takes precedence over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (|w_ovf_vec) begin
         r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign o_evt_valid = r_valid;
   assign o_evt_id    = r_id;
   assign o_evt_type  = r_type;
   assign o_ovf       = r_ovf;

endmodule

`default_nettype wire
